// File: rtl/ws2812_feeder_if.sv
// rtl/ws2812_feeder_if.sv - frame request, ROM/RAM fetch and PIO command bus of the WS2812 feeder
interface ws2812_feeder_if;
  logic        start;
  logic [7:0]  num_leds;
  logic [4:0]  prog_addr;
  logic [15:0] prog_data;
  logic [7:0]  pix_addr;
  logic [23:0] pix_data;
  logic        tx_full;
  logic [3:0]  action;
  logic [4:0]  index;
  logic [1:0]  mindex;
  logic [31:0] din;
  logic        busy;
  logic        done;

  modport master (
    output start, num_leds, prog_data, pix_data, tx_full,
    input  prog_addr, pix_addr, action, index, mindex, din, busy, done
  );

  modport slave (
    input  start, num_leds, prog_data, pix_data, tx_full,
    output prog_addr, pix_addr, action, index, mindex, din, busy, done
  );
endinterface

// File: rtl/ws2812_feeder.sv
// rtl/ws2812_feeder.sv - loads a WS2812 PIO program and config, then streams GRB pixels into the TX FIFO
module ws2812_feeder #(
  parameter int          PLEN       = 4,
  parameter logic [23:0] CLK_DIV    = 24'h0535,
  parameter logic [31:0] PIN_GRPS   = 32'h20000000,
  parameter logic [5:0]  SIDESET    = 6'b100001,
  parameter logic [31:0] SHIFT_CFG  = 32'h30020000,
  parameter int          GAP_CYCLES = 1250
) (
  input  logic          clk,
  input  logic          reset,
  ws2812_feeder_if.slave bus
);

  localparam logic [2:0] S_CFG_PROG = 3'd0;
  localparam logic [2:0] S_CFG_REGS = 3'd1;
  localparam logic [2:0] S_READY    = 3'd2;
  localparam logic [2:0] S_FETCH    = 3'd3;
  localparam logic [2:0] S_PUSH     = 3'd4;
  localparam logic [2:0] S_GAP      = 3'd5;

  localparam logic [3:0] A_NONE  = 4'd0;
  localparam logic [3:0] A_INSTR = 4'd1;
  localparam logic [3:0] A_PEND  = 4'd2;
  localparam logic [3:0] A_PUSH  = 4'd4;
  localparam logic [3:0] A_GRPS  = 4'd5;
  localparam logic [3:0] A_EN    = 4'd6;
  localparam logic [3:0] A_DIV   = 4'd7;
  localparam logic [3:0] A_SIDES = 4'd8;
  localparam logic [3:0] A_SHIFT = 4'd10;

  localparam int          GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [5:0]  PLEN_W   = 6'(PLEN);

  logic [2:0]    r_state;
  logic [5:0]    r_step;
  logic [4:0]    r_prog_addr;
  logic [7:0]    r_pix_addr;
  logic [7:0]    r_len;
  logic [23:0]   r_pix;
  logic          r_pix_ok;
  logic [GW-1:0] r_gap;
  logic          r_busy;
  logic [4:0]    r_index;
  logic [31:0]   r_din;

  logic [3:0]    w_action;
  logic [4:0]    w_index;
  logic [31:0]   w_din;
  logic [23:0]   w_pixel;
  logic          w_issue;
  logic [7:0]    w_cnt_nxt;
  logic          w_gap_end;

  // Commands are decoded combinationally so ROM/RAM data and tx_full act in the cycle they are valid;
  // index/din registers only remember the last issued values.
  always_comb begin
    w_action = A_NONE;
    w_index  = r_index;
    w_din    = r_din;
    w_pixel  = r_pix_ok ? r_pix : bus.pix_data;
    case (r_state)
      S_CFG_PROG: begin
        if (r_step != 6'd0) begin
          w_action = A_INSTR;
          w_index  = 5'(r_step - 6'd1);
          w_din    = {16'h0000, bus.prog_data};
        end
      end
      S_CFG_REGS: begin
        case (r_step[2:0])
          3'd0:    begin w_action = A_PEND;  w_din = 32'(PLEN - 1);       end
          3'd1:    begin w_action = A_DIV;   w_din = {8'h00, CLK_DIV};    end
          3'd2:    begin w_action = A_GRPS;  w_din = PIN_GRPS;            end
          3'd3:    begin w_action = A_SIDES; w_din = {26'h0, SIDESET};    end
          3'd4:    begin w_action = A_SHIFT; w_din = SHIFT_CFG;           end
          default: begin w_action = A_EN;    w_din = 32'd1;               end
        endcase
      end
      S_PUSH: begin
        if (!bus.tx_full) begin
          w_action = A_PUSH;
          w_din    = {w_pixel, 8'h00};
        end
      end
      default: ;
    endcase
    w_issue = (w_action != A_NONE);
  end

  assign w_cnt_nxt = r_pix_addr + 8'd1;
  assign w_gap_end = (r_state == S_GAP) && (r_gap == GAP_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_CFG_PROG;
      r_step      <= '0;
      r_prog_addr <= '0;
      r_pix_addr  <= '0;
      r_len       <= '0;
      r_pix       <= '0;
      r_pix_ok    <= 1'b0;
      r_gap       <= '0;
      r_busy      <= 1'b0;
      r_index     <= '0;
      r_din       <= '0;
    end else begin
      if (w_issue) begin
        r_index <= w_index;
        r_din   <= w_din;
      end
      case (r_state)
        S_CFG_PROG: begin
          if (r_step == PLEN_W) begin
            r_state <= S_CFG_REGS;
            r_step  <= '0;
          end else begin
            r_step <= r_step + 6'd1;
            if ((r_step + 6'd1) < PLEN_W) r_prog_addr <= 5'(r_step + 6'd1);
          end
        end
        S_CFG_REGS: begin
          if (r_step == 6'd5) begin
            r_state <= S_READY;
            r_step  <= '0;
          end else begin
            r_step <= r_step + 6'd1;
          end
        end
        S_READY: begin
          if (bus.start) begin
            r_busy     <= 1'b1;
            r_len      <= bus.num_leds;
            r_pix_addr <= '0;
            r_pix_ok   <= 1'b0;
            r_gap      <= '0;
            r_state    <= (bus.num_leds == 8'd0) ? S_GAP : S_FETCH;
          end
        end
        S_FETCH: begin
          r_pix_ok <= 1'b0;
          r_state  <= S_PUSH;
        end
        S_PUSH: begin
          if (w_issue) begin
            r_pix_ok   <= 1'b0;
            r_pix_addr <= w_cnt_nxt;
            r_state    <= (w_cnt_nxt == r_len) ? S_GAP : S_FETCH;
          end else begin
            // FIFO full: freeze the pixel so later RAM traffic cannot alter it
            r_pix    <= w_pixel;
            r_pix_ok <= 1'b1;
          end
        end
        S_GAP: begin
          if (w_gap_end) begin
            r_busy  <= 1'b0;
            r_state <= S_READY;
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        default: r_state <= S_CFG_PROG;
      endcase
    end
  end

  assign bus.prog_addr = r_prog_addr;
  assign bus.pix_addr  = r_pix_addr;
  assign bus.action    = w_action;
  assign bus.index     = w_index;
  assign bus.din       = w_din;
  assign bus.mindex    = 2'd0;
  assign bus.busy      = r_busy;
  assign bus.done      = w_gap_end;

endmodule

// File: doc/ws2812_feeder.md
WS2812_FEEDER -- requirements
Module: ws2812_feeder

Interface
REQ-001 Parameter PLEN, default 4, sets the number of PIO program words loaded (1..32).
REQ-002 Parameter CLK_DIV, default 24'h0535, sets the DIV action payload.
REQ-003 Parameter PIN_GRPS, default 32'h20000000, sets the GRPS action payload.
REQ-004 Parameter SIDESET, default 6'b100001, sets the SIDES action payload, zero-extended.
REQ-005 Parameter SHIFT_CFG, default 32'h30020000, sets the SHIFT action payload (autopull 24, shift left).
REQ-006 Parameter GAP_CYCLES, default 1250, sets the latch/reset gap after each frame (50 us at 25 MHz).
REQ-007 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-008 Port reset, input, 1: synchronous, active-high reset.
REQ-009 Port start, input, 1: one-cycle request to stream one frame.
REQ-010 Port num_leds, input, 8: pixel count of the frame, sampled when start is accepted.
REQ-011 Port prog_addr, output, 5: program ROM address.
REQ-012 Port prog_data, input, 16: ROM word, valid the cycle after prog_addr.
REQ-013 Port pix_addr, output, 8: pixel RAM address.
REQ-014 Port pix_data, input, 24: GRB pixel, valid the cycle after pix_addr.
REQ-015 Port tx_full, input, 1: PIO machine 0 TX FIFO full.
REQ-016 Ports action (4), index (5), mindex (2), din (32), all outputs: PIO command bus.
REQ-017 Ports busy and done, outputs, 1 each: busy is high from start acceptance through gap end; done is a one-cycle pulse at gap end.

Function
REQ-018 Action codes SHALL be NONE=0, INSTR=1, PEND=2, PUSH=4, GRPS=5, EN=6, DIV=7, SIDES=8, SHIFT=10; every non-NONE action SHALL last exactly one cycle.
REQ-019 States SHALL be CFG_PROG, CFG_REGS, READY, FETCH, PUSH, GAP.
REQ-020 After reset the block SHALL enter CFG_PROG and, for i=0..PLEN-1, drive prog_addr=i, then one cycle later issue INSTR with index=i and din={16'h0,prog_data}.
REQ-021 CFG_REGS SHALL issue on consecutive cycles: PEND din=PLEN-1, DIV, GRPS, SIDES, SHIFT, then EN din=1, then enter READY.
REQ-022 mindex SHALL be 0 at all times.
REQ-023 In READY with start=1 and num_leds>0, the block SHALL latch num_leds, set busy, and enter FETCH with pixel counter 0.
REQ-024 FETCH SHALL drive pix_addr=counter for one cycle, then enter PUSH holding the returned pixel in a register.
REQ-025 PUSH SHALL issue action=PUSH, din={pixel,8'h00} only in a cycle where tx_full=0; otherwise it SHALL hold action=NONE and the pixel.
REQ-026 After each PUSH the counter SHALL increment; if it reaches the latched count, the block SHALL enter GAP, else FETCH.
REQ-027 GAP SHALL last exactly GAP_CYCLES cycles with action=NONE, then pulse done, clear busy, and return to READY.
REQ-028 start with num_leds=0 SHALL go directly to GAP: no PUSH issued, done still pulsed.
REQ-029 start outside READY SHALL be ignored; start in the same cycle as config completion SHALL be ignored.
REQ-030 Outside an issuing cycle action SHALL be NONE; din and index SHALL hold their last value.

Reset
REQ-031 On reset: action=NONE, index=0, din=0, prog_addr=0, pix_addr=0, busy=0, done=0, counter=0, and state=CFG_PROG.
REQ-032 Reset asserted mid-frame SHALL abort the frame with no done pulse and rerun full configuration.

Verification
REQ-033 Reset release with PLEN=4 -> INSTR at index 0..3 carrying ROM words, then PEND 3, DIV 0x000535, GRPS 0x20000000, SIDES 0x21, SHIFT 0x30020000, EN 1, each one cycle.
REQ-034 start, num_leds=1, pix_data=0xFF00FF, tx_full=0 -> one PUSH din=0xFF00FF00; done exactly GAP_CYCLES cycles after the PUSH.
REQ-035 num_leds=3 with tx_full held high 10 cycles at the second pixel -> three PUSHes in address order, the second delayed 10 cycles, the pixel unchanged.
REQ-036 start with num_leds=0 -> no PUSH; busy high GAP_CYCLES cycles; done pulse once.
REQ-037 start pulsed during CFG_REGS and during GAP -> ignored; no extra PUSH or done.
REQ-038 reset asserted after first PUSH of a 3-pixel frame -> outputs at reset values next cycle, no done pulse, configuration sequence replays.
